// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake plus data-memory bus for
// the data-memory initiator. "slave" is the unit's view; "master" is the
// environment's view (CPU datapath driving requests, memory returning data).
interface mem_access_unit_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of the single-ported data memory.
// Accepts one load/store at a time, drives mem_read/mem_write with a held
// word address, and returns a one-cycle response pulse.
// Optional macro MISALIGN_TRAP_EN: when defined, a byte address with
// nonzero bits [1:0] is rejected like an out-of-range address.
module mem_access_unit #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    mem_access_unit_if.slave    bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam int              CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    logic [1:0]        state_r;
    logic              we_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;

    logic              addr_bad_s;
    logic [ADDR_W-1:0] word_idx_s;

    // Decode the word index and reject addresses outside the memory.
    always_comb begin
        word_idx_s = bus.req_addr[ADDR_W+1:2];
`ifdef MISALIGN_TRAP_EN
        addr_bad_s = (|(bus.req_addr >> (ADDR_W + 2))) || (bus.req_addr[1:0] != 2'b00);
`else
        addr_bad_s = |(bus.req_addr >> (ADDR_W + 2));
`endif
    end

    // Request FSM: IDLE accepts, ACCESS strobes memory, RESP pulses the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            we_r        <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    if (bus.req_valid) begin
                        we_r  <= bus.req_we;
                        cnt_r <= CNT_LOAD;
                        if (addr_bad_s) begin
                            // Rejected: skip memory, mem_addr/mem_wdata keep last value.
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_rdata_r <= {DATA_W{1'b0}};
                        end else begin
                            state_r     <= ACCESS;
                            mem_addr_r  <= word_idx_s;
                            mem_wdata_r <= bus.req_wdata;
                            mem_read_r  <= ~bus.req_we;
                            mem_write_r <= bus.req_we;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (we_r) begin
                        // Memory commits the write on the edge that ends this cycle.
                        mem_write_r <= 1'b0;
                        mem_read_r  <= 1'b0;
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b0;
                        rsp_rdata_r <= {DATA_W{1'b0}};
                    end else if (cnt_r == CNT_W'(0)) begin
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b0;
                        rsp_rdata_r <= bus.mem_rdata;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                RESP: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = (state_r == IDLE);
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.mem_read  = mem_read_r;
    assign bus.mem_write = mem_write_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized traffic against a
// transaction-level model of mem_access_unit with a behavioural data memory.
module tb_mem_access_unit;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int W  = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 0)      return 32'd17;
        else if (i == 1) return 32'd9;
        else if (i == 2) return 32'd25;
        else             return 32'(i) * 32'h0101_0101 + 32'd5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Environment data memory: posedge write, combinational read.
    logic [DW-1:0] env_mem [2**AW];
    assign bus.mem_rdata = env_mem[bus.mem_addr];
    initial begin
        for (int i = 0; i < 2**AW; i++) env_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (bus.mem_write === 1'b1) env_mem[bus.mem_addr] = bus.mem_wdata;
        end
    end

    // Reference model: one outstanding transaction, timed in cycles after acceptance.
    logic [DW-1:0] ref_mem [2**AW];
    logic          exp_ready = 1'b1, exp_read = 1'b0, exp_write = 1'b0, exp_rsp = 1'b0;
    logic          busy = 1'b0, m_we = 1'b0, m_err = 1'b0;
    logic [AW-1:0] m_idx = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;
    int            edge_n = 0, acc_edge = 0, rsp_k = 0, k = 0;
    initial begin
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = init_word(i);
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                busy = 1'b0; exp_ready = 1'b1; exp_read = 1'b0;
                exp_write = 1'b0; exp_rsp = 1'b0;
            end else begin
                edge_n++;
                if (exp_write) ref_mem[m_idx] = m_wdata;
                if (exp_ready && bus.req_valid === 1'b1) begin
                    acc_edge = edge_n;
                    busy     = 1'b1;
                    m_we     = bus.req_we;
                    m_idx    = bus.req_addr[AW+1:2];
                    m_wdata  = bus.req_wdata;
                    m_err    = (bus.req_addr >> (AW + 2)) != 32'd0;
`ifdef MISALIGN_TRAP_EN
                    if (bus.req_addr[1:0] != 2'b00) m_err = 1'b1;
`endif
                    m_rdata  = (m_err || m_we) ? 32'd0 : ref_mem[m_idx];
                    rsp_k    = m_err ? 0 : (m_we ? 1 : W + 1);
                end
                k = edge_n - acc_edge;
                if (busy && k > rsp_k) busy = 1'b0;
                exp_ready = !busy;
                exp_read  = busy && !m_err && !m_we && (k <= W);
                exp_write = busy && !m_err && m_we && (k == 0);
                exp_rsp   = busy && (k == rsp_k);
            end
        end
    end

    // Cycle compare of every DUT output against the model, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_req_ready", 32'(bus.req_ready), 32'd1);
                check("rst_mem_read",  32'(bus.mem_read),  32'd0);
                check("rst_mem_write", 32'(bus.mem_write), 32'd0);
                check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
                check("rst_mem_wdata", bus.mem_wdata,      32'd0);
                check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                check("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
                check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
            end else begin
                check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
                check("mem_read",  32'(bus.mem_read),  32'(exp_read));
                check("mem_write", 32'(bus.mem_write), 32'(exp_write));
                check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
                if (exp_read || exp_write) check("mem_addr", 32'(bus.mem_addr), 32'(m_idx));
                if (exp_write) check("mem_wdata", bus.mem_wdata, m_wdata);
                if (exp_rsp) begin
                    check("rsp_rdata", bus.rsp_rdata, m_rdata);
                    check("rsp_err",   32'(bus.rsp_err), 32'(m_err));
                end
            end
        end
    end

    // Response monitor for ordering/duplication checks.
    logic [DW-1:0] rsp_q [$];
    initial begin
        forever begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) rsp_q.push_back(bus.rsp_rdata);
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int nrd, output int nwr, output logic [31:0] seen_addr);
        int   n;
        logic got;
        rdata = '0; err = 1'b0; lat = 0; nrd = 0; nwr = 0; seen_addr = '0; got = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(n < 50), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!got && n < 50) begin
            lat++;
            if (bus.mem_read === 1'b1)  begin nrd++; seen_addr = 32'(bus.mem_addr); end
            if (bus.mem_write === 1'b1) begin nwr++; seen_addr = 32'(bus.mem_addr); end
            if (bus.rsp_valid === 1'b1) begin
                got = 1'b1; rdata = bus.rsp_rdata; err = bus.rsp_err;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        check("rsp_timeout", 32'(got), 32'd1);
    endtask

    logic [31:0] rd, sa;
    logic        er;
    int          lat, nrd, nwr;
    logic        will_accept;

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Load of word 1 with one wait cycle.
        do_req(1'b0, 32'h4, 32'h0, rd, er, lat, nrd, nwr, sa);
        check("ld4_data", rd, 32'd9);
        check("ld4_err", 32'(er), 32'd0);
        check("ld4_lat", 32'(lat), 32'd3);
        check("ld4_nread", 32'(nrd), 32'd2);
        check("ld4_nwrite", 32'(nwr), 32'd0);
        check("ld4_addr", sa, 32'd1);

        // Out-of-range address.
        do_req(1'b0, 32'h80, 32'h0, rd, er, lat, nrd, nwr, sa);
        check("oor_err", 32'(er), 32'd1);
        check("oor_data", rd, 32'd0);
        check("oor_lat", 32'(lat), 32'd1);
        check("oor_strobes", 32'(nrd + nwr), 32'd0);

        // Misaligned address.
        do_req(1'b0, 32'h6, 32'h0, rd, er, lat, nrd, nwr, sa);
`ifdef MISALIGN_TRAP_EN
        check("mis_err", 32'(er), 32'd1);
        check("mis_data", rd, 32'd0);
        check("mis_strobes", 32'(nrd + nwr), 32'd0);
`else
        check("mis_err", 32'(er), 32'd0);
        check("mis_data", rd, 32'd9);
`endif

        // Three back-to-back loads with req_valid held high.
        repeat (2) @(negedge clk);
        rsp_q.delete();
        bus.req_valid = 1'b1; bus.req_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            int n;
            bus.req_addr = 32'(4 * i);
            n = 0;
            while (bus.req_ready !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("b2b_accept_timeout", 32'(n < 20), 32'd1);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("b2b_count", 32'(rsp_q.size()), 32'd3);
        if (rsp_q.size() == 3) begin
            check("b2b_rsp0", rsp_q[0], 32'd17);
            check("b2b_rsp1", rsp_q[1], 32'd9);
            check("b2b_rsp2", rsp_q[2], 32'd25);
        end

        // Store aborted by reset before its write edge.
        rsp_q.delete();
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h0; bus.req_wdata = 32'h1234_5678;
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_no_rsp", 32'(rsp_q.size()), 32'd0);
        do_req(1'b0, 32'h0, 32'h0, rd, er, lat, nrd, nwr, sa);
        check("rst_ld0_data", rd, 32'd17);

        // Store then reload of word 2.
        do_req(1'b1, 32'h8, 32'hDEAD_BEEF, rd, er, lat, nrd, nwr, sa);
        check("st8_data", rd, 32'd0);
        check("st8_err", 32'(er), 32'd0);
        check("st8_lat", 32'(lat), 32'd2);
        check("st8_nwrite", 32'(nwr), 32'd1);
        check("st8_nread", 32'(nrd), 32'd0);
        check("st8_addr", sa, 32'd2);
        do_req(1'b0, 32'h8, 32'h0, rd, er, lat, nrd, nwr, sa);
        check("ld8_data", rd, 32'hDEAD_BEEF);

        // Randomized traffic; requester holds each request until accepted.
        will_accept = 1'b0;
        repeat (3000) begin
            @(negedge clk);
            if (bus.req_valid !== 1'b1 || will_accept) begin
                if ($urandom_range(0, 9) < 6) begin
                    bus.req_valid = 1'b1;
                    bus.req_we    = 1'($urandom_range(0, 1));
                    bus.req_wdata = $urandom;
                    if ($urandom_range(0, 9) == 0)
                        bus.req_addr = $urandom | (32'h80 << $urandom_range(0, 24));
                    else
                        bus.req_addr = {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            will_accept = (bus.req_valid === 1'b1) && (bus.req_ready === 1'b1);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
